// File: rtl/motor_plant_responder.sv
// Plant-side agent for the f/g motor controller: answers an f pulse with the
// x sequence 0,1,0,1, drives y once g is granted, then grades the final g.
module motor_plant_responder #(
  parameter int CW           = 8,
  parameter int Y_WINDOW     = 2,
  parameter int CHECK_CYCLES = 4,
  parameter int G_TIMEOUT    = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          f,
  input  logic          g,
  input  logic [CW-1:0] x_hold,
  input  logic [CW-1:0] y_delay,
  input  logic          y_en,
  output logic          x,
  output logic          y,
  output logic          busy,
  output logic          done,
  output logic          pass,
  output logic          err
);

  localparam logic [3:0] S_IDLE  = 4'd0;
  localparam logic [3:0] S_XA    = 4'd1;
  localparam logic [3:0] S_XB    = 4'd2;
  localparam logic [3:0] S_XC    = 4'd3;
  localparam logic [3:0] S_XD    = 4'd4;
  localparam logic [3:0] S_WAITG = 4'd5;
  localparam logic [3:0] S_YDLY  = 4'd6;
  localparam logic [3:0] S_CHECK = 4'd7;
  localparam logic [3:0] S_DONE  = 4'd8;

  localparam logic [CW-1:0] YW_C    = CW'(Y_WINDOW);
  localparam logic [CW-1:0] CC_C    = CW'(CHECK_CYCLES);
  localparam logic [CW-1:0] GT_LAST = CW'(G_TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

  logic [3:0]    state;
  logic [CW-1:0] cnt;
  logic [CW-1:0] hold_q;
  logic [CW-1:0] dly_q;
  logic          yen_q;
  logic          keep_q;

  logic [CW-1:0] cnt_inc;
  logic [CW-1:0] hold_eff;
  logic          phase_end;

  assign cnt_inc   = (cnt == CNT_MAX) ? cnt : cnt + CW'(1);
  assign hold_eff  = (x_hold == '0) ? CW'(1) : x_hold;
  assign phase_end = (cnt == hold_q - CW'(1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= S_IDLE;
      cnt    <= '0;
      hold_q <= '0;
      dly_q  <= '0;
      yen_q  <= 1'b0;
      keep_q <= 1'b0;
      x      <= 1'b0;
      y      <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      pass   <= 1'b0;
      err    <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (f) begin
            hold_q <= hold_eff;
            dly_q  <= y_delay;
            yen_q  <= y_en;
            keep_q <= y_en && (y_delay < YW_C);
            cnt    <= '0;
            x      <= 1'b0;
            y      <= 1'b0;
            busy   <= 1'b1;
            done   <= 1'b0;
            pass   <= 1'b0;
            err    <= 1'b0;
            state  <= S_XA;
          end
        end
        S_XA, S_XB, S_XC, S_XD: begin
          if (phase_end) begin
            cnt <= '0;
            // XA/XC lead into a high phase, XB into a low one; x stays high past XD
            x   <= (state != S_XB);
            case (state)
              S_XA:    state <= S_XB;
              S_XB:    state <= S_XC;
              S_XC:    state <= S_XD;
              default: state <= S_WAITG;
            endcase
          end else begin
            cnt <= cnt_inc;
          end
        end
        S_WAITG: begin
          if (g) begin
            cnt   <= '0;
            y     <= yen_q && (dly_q == '0);
            state <= S_YDLY;
          end else if (cnt == GT_LAST) begin
            err   <= 1'b1;
            pass  <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= S_DONE;
          end else begin
            cnt <= cnt_inc;
          end
        end
        S_YDLY: begin
          if (yen_q) begin
            // y is a single-cycle pulse; the phase ends on the edge after it
            if (y) begin
              y     <= 1'b0;
              cnt   <= '0;
              state <= S_CHECK;
            end else begin
              cnt <= cnt_inc;
              y   <= (cnt_inc == dly_q);
            end
          end else if (cnt == YW_C) begin
            cnt   <= '0;
            state <= S_CHECK;
          end else begin
            cnt <= cnt_inc;
          end
        end
        S_CHECK: begin
          if (cnt == CC_C) begin
            pass  <= (g == keep_q);
            err   <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= S_DONE;
          end else begin
            cnt <= cnt_inc;
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_motor_plant_responder.sv
// Directed plus randomized transactions against a timing model built from the
// plant agent's behavioural rules; a controller model drives g.
module tb_motor_plant_responder;

  localparam int YW  = 2;
  localparam int GTO = 16;

  logic       clk = 1'b0;
  logic       reset, f, g, y_en;
  logic [7:0] x_hold, y_delay;
  logic       x, y, busy, done, pass, err;

  int nvec = 0;
  int nerr = 0;

  motor_plant_responder dut (
    .clk(clk), .reset(reset), .f(f), .g(g),
    .x_hold(x_hold), .y_delay(y_delay), .y_en(y_en),
    .x(x), .y(y), .busy(busy), .done(done), .pass(pass), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    nvec++;
    assert (obs === expv) else begin
      nerr++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One start-to-done exchange; expected timing derives from hold, delay and window rules.
  task automatic run_txn(input int h, input int d, input bit en, input bit gfin,
                         input int gdel, input bit tmo, input bit fwait);
    int  hh;
    int  limit;
    int  n;
    bit  keep;
    hh   = (h == 0) ? 1 : h;
    keep = en && (d < YW);
    f = 1'b1; x_hold = 8'(h); y_delay = 8'(d); y_en = en; g = 1'b0;
    step();
    f = 1'b0;
    chk("start_done_clr", {7'd0, done}, 8'd0);
    chk("start_err_clr", {7'd0, err}, 8'd0);
    for (int p = 0; p < 4; p++) begin
      for (int c = 0; c < hh; c++) begin
        chk("x_phase", {7'd0, x}, 8'(p % 2));
        chk("busy_x", {7'd0, busy}, 8'd1);
        step();
      end
    end
    chk("x_after_xd", {7'd0, x}, 8'd1);
    if (tmo) begin
      for (int j = 0; j < GTO; j++) begin
        chk("no_done_waitg", {7'd0, done}, 8'd0);
        step();
      end
      chk("tmo_done", {7'd0, done}, 8'd1);
      chk("tmo_err", {7'd0, err}, 8'd1);
      chk("tmo_pass", {7'd0, pass}, 8'd0);
      chk("tmo_busy", {7'd0, busy}, 8'd0);
      return;
    end
    for (int j = 0; j < gdel; j++) begin
      chk("waitg_busy", {7'd0, busy}, 8'd1);
      chk("waitg_x", {7'd0, x}, 8'd1);
      if (fwait && j == 1) begin
        f = 1'b1; x_hold = 8'($urandom); y_delay = 8'($urandom); y_en = 1'($urandom);
      end else begin
        f = 1'b0;
      end
      step();
    end
    f = 1'b0;
    g = 1'b1;
    step();
    limit = en ? d + 1 : YW + 1;
    for (int j = 0; j <= limit; j++) begin
      chk("y_level", {7'd0, y}, {7'd0, (en && j == d)});
      chk("ydly_busy", {7'd0, busy}, 8'd1);
      if (j < limit) begin
        g = 1'($urandom_range(0, 1));
        step();
      end
    end
    g = gfin;
    n = 0;
    while (n < 20 && !done) begin
      step();
      n++;
    end
    chk("done_seen", {7'd0, done}, 8'd1);
    chk("pass_value", {7'd0, pass}, {7'd0, (gfin == keep)});
    chk("err_clear", {7'd0, err}, 8'd0);
    chk("done_busy", {7'd0, busy}, 8'd0);
    chk("done_x", {7'd0, x}, 8'd1);
    chk("done_y", {7'd0, y}, 8'd0);
  endtask

  initial begin
    reset = 1'b1; f = 1'b0; g = 1'b0; y_en = 1'b0; x_hold = '0; y_delay = '0;
    step();
    step();
    chk("rst_x", {7'd0, x}, 8'd0);
    chk("rst_y", {7'd0, y}, 8'd0);
    chk("rst_busy", {7'd0, busy}, 8'd0);
    chk("rst_done", {7'd0, done}, 8'd0);
    chk("rst_pass", {7'd0, pass}, 8'd0);
    chk("rst_err", {7'd0, err}, 8'd0);
    reset = 1'b0;
    step();

    run_txn(1, 0, 1'b1, 1'b1, 2, 1'b0, 1'b0);
    run_txn(3, 1, 1'b1, 1'b1, 0, 1'b0, 1'b0);
    run_txn(2, 5, 1'b1, 1'b0, 1, 1'b0, 1'b0);
    run_txn(2, 5, 1'b1, 1'b1, 1, 1'b0, 1'b0);
    run_txn(1, 3, 1'b0, 1'b0, 4, 1'b0, 1'b0);
    run_txn(1, 0, 1'b0, 1'b1, 4, 1'b0, 1'b0);
    run_txn(0, 0, 1'b1, 1'b1, 3, 1'b0, 1'b0);
    run_txn(1, 255, 1'b1, 1'b0, 0, 1'b0, 1'b0);
    run_txn(2, 0, 1'b0, 1'b0, 0, 1'b1, 1'b0);
    run_txn(1, 1, 1'b1, 1'b1, 5, 1'b0, 1'b1);

    // Abort mid-sequence in XC, then restart cleanly
    f = 1'b1; x_hold = 8'd3; y_delay = 8'd0; y_en = 1'b1; g = 1'b0;
    step();
    f = 1'b0;
    repeat (6) step();
    chk("xc_x", {7'd0, x}, 8'd0);
    chk("xc_busy", {7'd0, busy}, 8'd1);
    reset = 1'b1;
    step();
    chk("rst_mid_x", {7'd0, x}, 8'd0);
    chk("rst_mid_busy", {7'd0, busy}, 8'd0);
    chk("rst_mid_done", {7'd0, done}, 8'd0);
    reset = 1'b0;
    step();
    chk("idle_busy", {7'd0, busy}, 8'd0);
    run_txn(2, 1, 1'b1, 1'b1, 1, 1'b0, 1'b0);

    for (int t = 0; t < 30; t++) begin
      run_txn($urandom_range(0, 4), $urandom_range(0, 6), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), $urandom_range(0, 10),
              ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
